// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide, one bit per cycle)
//   clk, rst          : clock and synchronous active-high reset
//   start, func3      : request and M-op select, sampled in IDLE or DONE
//   flush             : abandons any operation in progress
//   rs1, rs2          : operands A and B
//   busy, done, result: iterating, one-cycle completion pulse, held result
//   MULDIV_FAST_MUL_EN: when defined, multiplies use a single-cycle combinational multiplier
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d, mstep, dstep, prod;
    logic [XLEN-1:0] opd_q, opd_d, res_q, res_d, ma, mb, qv, rv, dif, fin;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] f3_q, f3_d;
    logic sq_q, sq_d, sr_q, sr_d;
    logic sa, sb, na, nb, dz, ovf, accept, ge;
    logic [XLEN:0] sum, sh;

    assign sa = func3[2] ? ~func3[0] : func3[0] ^ func3[1];
    assign sb = func3[2] ? ~func3[0] : func3[1:0] == 2'b01;
    assign na = sa & rs1[XLEN-1];
    assign nb = sb & rs2[XLEN-1];
    assign ma = na ? -rs1 : rs1;
    assign mb = nb ? -rs2 : rs2;
    assign dz = func3[2] & ~|rs2;
    assign ovf = func3[2] & ~func3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
    assign accept = start & (state_q == IDLE || state_q == DONE);

    // multiply: add the multiplicand into the upper half when the multiplier LSB is set, then shift right
    assign sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mstep = {sum, acc_q[XLEN-1:1]};
    // divide: shift the next dividend bit into the remainder, subtract the divisor when it fits
    assign sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign ge = sh >= {1'b0, opd_q};
    assign dif = sh[XLEN-1:0] - opd_q;
    assign dstep = {ge ? dif : sh[XLEN-1:0], acc_q[XLEN-2:0], ge};

    // sign fix-up: the product is negated over its full width before the half is selected
    assign prod = sq_q ? -acc_q : acc_q;
    assign qv = sq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rv = sr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign fin = ~f3_q[2] ? (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                          : (f3_q[1] ? rv : qv);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fp;
    // sign-extended operands make the low 2*XLEN bits of an unsigned product the signed product
    assign fp = {{XLEN{na}}, rs1} * {{XLEN{nb}}, rs2};
`endif

    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        opd_d = opd_q;
        res_d = res_q;
        cnt_d = cnt_q;
        f3_d = f3_q;
        sq_d = sq_q;
        sr_d = sr_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            f3_d = func3;
            opd_d = func3[2] ? mb : ma;
            acc_d = {{XLEN{1'b0}}, func3[2] ? ma : mb};
            sq_d = na ^ nb;
            sr_d = na;
            cnt_d = CW'(XLEN - 1);
            state_d = CALC;
            if (dz | ovf) begin
                // quotient preloaded in the low half, remainder in the high half
                acc_d = dz ? {rs1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, rs1};
                sq_d = 1'b0;
                sr_d = 1'b0;
                state_d = FIX;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (~func3[2]) begin
                acc_d = fp;
                sq_d = 1'b0;
                state_d = FIX;
            end
`endif
        end else if (state_q == CALC) begin
            acc_d = f3_q[2] ? dstep : mstep;
            cnt_d = cnt_q - 1'b1;
            state_d = cnt_q == '0 ? FIX : CALC;
        end else if (state_q == FIX) begin
            res_d = fin;
            state_d = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            opd_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
            f3_q <= '0;
            sq_q <= 1'b0;
            sr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            opd_q <= opd_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
            f3_q <= f3_d;
            sq_q <= sq_d;
            sr_q <= sr_d;
        end
    end

    assign busy = state_q == CALC;
    assign done = state_q == DONE;
    assign result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2, result;
    logic        busy, done;
    int total = 0;
    int bad = 0;
    logic [31:0] last = '0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MLAT = 1;
`else
    localparam int MLAT = 33;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .func3(func3),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        logic ov;
        sa = a;
        sb = b;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int elat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return f[2] ? 33 : MLAT;
    endfunction

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bc, output logic [31:0] r);
        @(negedge clk);
        func3 = f; rs1 = a; rs2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; func3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        lat = 0; bc = 0;
        while (done !== 1'b1 && lat < 100) begin
            bc += int'(busy);
            @(negedge clk);
            lat++;
        end
        r = result;
    endtask

    task automatic test_reset;
        int seen;
        rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        rst = 1'b0;
        seen = 0;
        repeat (10) begin @(negedge clk); seen += int'(done === 1'b1 || busy === 1'b1); end
        total++; if (seen != 0) begin bad++; $display("FAIL idle_quiet got=%0d active cycles want=0", seen); end
        last = '0;
    endtask

    task automatic test_vectors;
        logic [2:0]  f[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd6};
        logic [31:0] a[12] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF,
                               32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd5, 32'd5, 32'h80000000};
        logic [31:0] b[12] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd2,
                               32'd0, 32'd0, 32'hFFFFFFFF};
        logic [31:0] w[12] = '{32'hFFFFFFFA, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001,
                               32'hFFFFFFFF, 32'h00000005, 32'h00000000};
        int wl[12] = '{MLAT, MLAT, MLAT, MLAT, MLAT, 33, 33, 33, 33, 1, 1, 1};
        int lat, bc;
        logic [31:0] r;
        for (int i = 0; i < 12; i++) begin
            run(f[i], a[i], b[i], lat, bc, r);
            total++; if (r !== w[i]) begin bad++; $display("FAIL vec%0d_result got=%h want=%h", i, r, w[i]); end
            total++; if (lat != wl[i]) begin bad++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, wl[i]); end
            total++; if (bc != (wl[i] == 1 ? 0 : 32)) begin
                bad++; $display("FAIL vec%0d_busy got=%0d want=%0d", i, bc, wl[i] == 1 ? 0 : 32);
            end
            @(negedge clk);
            total++; if (done !== 1'b0) begin bad++; $display("FAIL vec%0d_pulse got=%b want=0", i, done); end
            last = w[i];
        end
    endtask

    task automatic test_random;
        logic [2:0] f;
        logic [31:0] a, b, w;
        int lat, bc, wl;
        logic [31:0] r;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
            w = model(f, a, b);
            wl = elat(f, a, b);
            run(f, a, b, lat, bc, r);
            total++; if (r !== w) begin bad++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h want=%h", i, f, a, b, r, w); end
            total++; if (lat != wl) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, wl); end
            total++; if (bc != (wl == 1 ? 0 : 32)) begin bad++; $display("FAIL rnd%0d_busy got=%0d want=%0d", i, bc, wl == 1 ? 0 : 32); end
            last = w;
        end
    endtask

    task automatic test_flush;
        int seen;
        @(negedge clk);
        func3 = 3'd5; rs1 = $urandom; rs2 = $urandom | 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL flush_idle got busy=%b done=%b want 0/0", busy, done);
        end
        seen = 0;
        repeat (40) begin @(negedge clk); seen += int'(done === 1'b1 || busy === 1'b1); end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_nodone got=%0d active cycles want=0", seen); end
        total++; if (result !== last) begin bad++; $display("FAIL flush_result got=%h want=%h", result, last); end
        func3 = 3'd4; rs1 = $urandom; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (40) begin seen += int'(done === 1'b1 || busy === 1'b1); @(negedge clk); end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_start_drop got=%0d active cycles want=0", seen); end
        total++; if (result !== last) begin bad++; $display("FAIL flush_start_result got=%h want=%h", result, last); end
    endtask

    task automatic test_start_in_calc;
        logic [31:0] a, b, w;
        int lat, seen;
        a = $urandom; b = ($urandom >> 8) | 32'h1;
        w = model(3'd7, a, b);
        @(negedge clk);
        func3 = 3'd7; rs1 = a; rs2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            start = (lat == 5) ? 1'b1 : 1'b0;
            func3 = 3'd0; rs1 = $urandom; rs2 = $urandom;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        total++; if (lat != 33) begin bad++; $display("FAIL calc_start_latency got=%0d want=33", lat); end
        total++; if (result !== w) begin bad++; $display("FAIL calc_start_result got=%h want=%h", result, w); end
        last = w;
        seen = 0;
        repeat (40) begin @(negedge clk); seen += int'(done === 1'b1 || busy === 1'b1); end
        total++; if (seen != 0) begin bad++; $display("FAIL calc_start_queued got=%0d active cycles want=0", seen); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b, w1, w2;
        int lat, bc;
        logic [31:0] r;
        a = $urandom; b = ($urandom >> 4) | 32'h1;
        w1 = model(3'd5, a, b);
        run(3'd5, a, b, lat, bc, r);
        total++; if (r !== w1) begin bad++; $display("FAIL b2b_first got=%h want=%h", r, w1); end
        a = $urandom; b = $urandom | 32'h1;
        w2 = model(3'd6, a, b);
        func3 = 3'd6; rs1 = a; rs2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        total++; if (lat != 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
        total++; if (result !== w2) begin bad++; $display("FAIL b2b_second got=%h want=%h", result, w2); end
        last = w2;
    endtask

    task automatic test_rst_mid;
        int seen;
        @(negedge clk);
        func3 = 3'd3; rs1 = $urandom; rs2 = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin seen += int'(done === 1'b1 || busy === 1'b1); @(negedge clk); end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_quiet got=%0d active cycles want=0", seen); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", result); end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_random;
        test_flush;
        test_start_in_calc;
        test_back_to_back;
        test_rst_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
